wb_uart_arb: RTL and testbench
==============================

# wb_uart_arb

Two-master Wishbone arbiter that shares the single UART Wishbone slave port between two requesters (e.g. CPU and a DMA/test master). It sits directly in front of the UART register file. It does three things:
- Grants the slave to one master per transaction, round-robin.
- Muxes address, write enable and data to the slave.
- Routes the slave's data/ack/err back to the owning master only.

An optional watchdog terminates transactions the slave never answers.

## Interface
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 16, watchdog limit in cycles (used only with the timeout feature)

Ports:
- i_clk  in  1  single clock; all logic on rising edge
- i_rst_n  in  1  reset, asynchronous assert, active-low
- i_m0_adr / i_m1_adr  in  AW  master address
- i_m0_we / i_m1_we  in  1  master write enable
- i_m0_dat / i_m1_dat  in  DW  master write data
- i_m0_stb / i_m1_stb  in  1  master request; held high until ack/err
- o_m0_dat / o_m1_dat  out  DW  read data to master
- o_m0_ack / o_m1_ack  out  1  transaction done
- o_m0_err / o_m1_err  out  1  transaction error
- o_s_adr  out  AW  slave address
- o_s_we  out  1  slave write enable
- o_s_dat  out  DW  slave write data
- o_s_stb  out  1  slave request
- i_s_dat  in  DW  slave read data
- i_s_ack  in  1  slave ack
- i_s_err  in  1  slave error
- o_owner  out  1  current/last owner (0 = m0, 1 = m1)
- o_busy  out  1  state is BUS

## Operation
States:
- IDLE: no master owns the slave.
- BUS: the registered `owner` holds the slave.

Registered state:
- `last` records the most recent owner.
- Reset value: `last` = 1, so m0 wins the first tie.

IDLE → BUS:
- Taken when any stb is high.
- Single requester: that requester is granted.
- Both requesting: the master ≠ `last` is granted.

In BUS (combinational):
- o_s_adr / o_s_we / o_s_dat follow the owner's inputs.
- o_s_stb = owner's stb.

In IDLE:
- All o_s_* are 0.

Response routing:
- Owner receives o_mX_dat = i_s_dat, o_mX_ack = i_s_ack & ~i_s_err, o_mX_err = i_s_err.
- Non-owner receives all zeros, always.
- Simultaneous i_s_ack and i_s_err: err wins and ack is suppressed.

BUS → IDLE occurs on any of:
- i_s_ack or i_s_err.
- Owner drops stb (abort): any response that cycle is ignored and not forwarded.
- Watchdog expiry (see Configuration).

On the BUS → IDLE transition, `last` ← owner.

A request from the non-owner arriving during BUS waits. It is granted at the next IDLE evaluation.

## Timing
- Grant latency: stb seen in IDLE at cycle N → BUS and o_s_stb high at N+1.
- Response path: slave ack/err/dat reach the owner combinationally in the same cycle.
- Minimum transaction: 2 cycles, with a zero-wait slave acking at N+1.
- Mandatory gap: at least 1 IDLE cycle between consecutive grants.
  - A master re-asserting stb continuously gets its next grant 2 cycles after its ack.
  - Under contention, grants strictly alternate.
- Reset values: all outputs 0, including o_owner and o_busy; state IDLE.
- Reset asserted mid-BUS:
  - o_s_stb and all master outputs go to 0 asynchronously.
  - Any pending transaction is dropped.
  - No ack or err is issued for it.

## Configuration
- Macro: WB_ARB_TIMEOUT_EN.

When defined:
- A counter of width $clog2(TIMEOUT)+1 clears on entry to BUS and increments each BUS cycle without a response.
- Expiry is the TIMEOUT-th consecutive BUS cycle with no i_s_ack/i_s_err. On that cycle:
  - o_mX_err = 1 to the owner for that single cycle.
  - o_s_stb is forced 0.
  - Next state is IDLE and `last` updates.
- A genuine ack/err on the expiry cycle takes precedence: it is forwarded normally and the watchdog err is suppressed.

When undefined:
- No counter exists.
- BUS waits indefinitely.
- TIMEOUT is ignored.

## Test plan
- Reset: hold i_rst_n = 0 with both stbs high → every output 0; release → m0 granted on the next edge (o_owner = 0, o_busy = 1).
- m0 write adr 0x10 dat 0xA5, slave acks 1 cycle after o_s_stb:
  - o_s_adr = 0x10, o_s_dat = 0xA5, o_s_we = 1.
  - o_m0_ack high for exactly 1 cycle.
  - All m1 outputs stay 0.
- Both masters stb continuously, slave zero-wait ack, m1 read returns i_s_dat = 0xDEADBEEF:
  - Grant order is m0, m1, m0, m1.
  - o_m1_dat = 0xDEADBEEF on its ack cycle.
  - One IDLE cycle between grants.
- Slave asserts i_s_ack and i_s_err together for m1 → o_m1_err = 1, o_m1_ack = 0; next cycle IDLE.
- WB_ARB_TIMEOUT_EN, TIMEOUT = 16, slave silent, m0 requests → o_m0_err pulses on the 16th BUS cycle; then m1's pending request is granted 2 cycles later.
- i_rst_n pulsed low during m1's BUS state → o_s_stb = 0 immediately; no ack/err to m1; after release, with both requesting, m0 is granted first.

Source files
------------

// File: rtl/wb_uart_arb.sv
// wb_uart_arb: two-master Wishbone arbiter in front of the UART register file.
// Round-robin grant per transaction. Address, write-enable and data are muxed
// from the owning master to the slave. Responses are routed back to the owner
// only.
// Optional watchdog: define WB_ARB_TIMEOUT_EN to terminate transactions the
// slave never answers (after TIMEOUT silent BUS cycles).
module wb_uart_arb #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [AW-1:0] i_m0_adr,
    input  logic          i_m0_we,
    input  logic [DW-1:0] i_m0_dat,
    input  logic          i_m0_stb,
    input  logic [AW-1:0] i_m1_adr,
    input  logic          i_m1_we,
    input  logic [DW-1:0] i_m1_dat,
    input  logic          i_m1_stb,
    output logic [DW-1:0] o_m0_dat,
    output logic          o_m0_ack,
    output logic          o_m0_err,
    output logic [DW-1:0] o_m1_dat,
    output logic          o_m1_ack,
    output logic          o_m1_err,
    output logic [AW-1:0] o_s_adr,
    output logic          o_s_we,
    output logic [DW-1:0] o_s_dat,
    output logic          o_s_stb,
    input  logic [DW-1:0] i_s_dat,
    input  logic          i_s_ack,
    input  logic          i_s_err,
    output logic          o_owner,
    output logic          o_busy
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUS  = 1'b1
    } state_t;

    state_t state_reg, state_next;
    logic   owner_reg, owner_next;   // master holding (or last holding) the slave
    logic   last_reg,  last_next;    // most recent owner, for round-robin

    logic   owner_stb;               // strobe of the current owner
    logic   slave_resp;              // slave answered this cycle
    logic   wd_expire;               // watchdog fires this cycle
    logic   txn_done;                // BUS ends this cycle

    assign owner_stb  = owner_reg ? i_m1_stb : i_m0_stb;
    assign slave_resp = i_s_ack | i_s_err;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT) + 1;

    logic [CW-1:0] wd_cnt_reg;

    // Watchdog counts silent BUS cycles; expiry on the TIMEOUT-th one, but a
    // genuine response on that same cycle takes precedence.
    assign wd_expire = (state_reg == ST_BUS) && !slave_resp &&
                       (wd_cnt_reg == CW'(TIMEOUT - 1));

    // Watchdog counter: cleared on grant, advanced on each silent BUS cycle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wd_cnt_reg <= '0;
        end else if (state_reg == ST_IDLE) begin
            wd_cnt_reg <= '0;
        end else if (!txn_done) begin
            wd_cnt_reg <= wd_cnt_reg + 1'b1;
        end
    end
`else
    assign wd_expire = 1'b0;
`endif

    // An owner dropping its strobe aborts the transaction outright
    assign txn_done = !owner_stb || slave_resp || wd_expire;

    // State, owner and round-robin history registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= ST_IDLE;
            owner_reg <= 1'b0;
            last_reg  <= 1'b1;           // so m0 wins the first tie
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
            last_reg  <= last_next;
        end
    end

    // Next-state: grant in IDLE, release in BUS when the transaction ends
    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        last_next  = last_reg;
        case (state_reg)
            ST_IDLE: begin
                if (i_m0_stb || i_m1_stb) begin
                    state_next = ST_BUS;
                    if (i_m0_stb && i_m1_stb) begin
                        owner_next = ~last_reg;
                    end else begin
                        owner_next = i_m1_stb;
                    end
                end
            end
            ST_BUS: begin
                if (txn_done) begin
                    state_next = ST_IDLE;
                    last_next  = owner_reg;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs: slave mux from owner, responses to owner only, zeros otherwise
    always_comb begin
        o_s_adr  = '0;
        o_s_we   = 1'b0;
        o_s_dat  = '0;
        o_s_stb  = 1'b0;
        o_m0_dat = '0;
        o_m0_ack = 1'b0;
        o_m0_err = 1'b0;
        o_m1_dat = '0;
        o_m1_ack = 1'b0;
        o_m1_err = 1'b0;
        o_owner  = owner_reg;
        o_busy   = (state_reg == ST_BUS);
        if (state_reg == ST_BUS) begin
            o_s_adr = owner_reg ? i_m1_adr : i_m0_adr;
            o_s_we  = owner_reg ? i_m1_we  : i_m0_we;
            o_s_dat = owner_reg ? i_m1_dat : i_m0_dat;
            o_s_stb = owner_stb && !wd_expire;
            // Responses during an abort are swallowed
            if (owner_stb) begin
                if (owner_reg) begin
                    o_m1_dat = i_s_dat;
                    o_m1_ack = i_s_ack && !i_s_err;
                    o_m1_err = i_s_err || wd_expire;
                end else begin
                    o_m0_dat = i_s_dat;
                    o_m0_ack = i_s_ack && !i_s_err;
                    o_m0_err = i_s_err || wd_expire;
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_uart_arb.sv
// Testbench for wb_uart_arb: directed scenarios followed by randomized traffic,
// all outputs compared each cycle against a transaction-level reference model.
module tb_wb_uart_arb;

    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int TIMEOUT = 16;

    logic          i_clk = 1'b0;
    logic          i_rst_n;
    logic [AW-1:0] i_m0_adr, i_m1_adr;
    logic          i_m0_we,  i_m1_we;
    logic [DW-1:0] i_m0_dat, i_m1_dat;
    logic          i_m0_stb, i_m1_stb;
    logic [DW-1:0] o_m0_dat, o_m1_dat;
    logic          o_m0_ack, o_m1_ack, o_m0_err, o_m1_err;
    logic [AW-1:0] o_s_adr;
    logic          o_s_we;
    logic [DW-1:0] o_s_dat;
    logic          o_s_stb;
    logic [DW-1:0] i_s_dat;
    logic          i_s_ack, i_s_err;
    logic          o_owner, o_busy;

    always #5 i_clk = ~i_clk;

    wb_uart_arb #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_m0_adr(i_m0_adr), .i_m0_we(i_m0_we), .i_m0_dat(i_m0_dat), .i_m0_stb(i_m0_stb),
        .i_m1_adr(i_m1_adr), .i_m1_we(i_m1_we), .i_m1_dat(i_m1_dat), .i_m1_stb(i_m1_stb),
        .o_m0_dat(o_m0_dat), .o_m0_ack(o_m0_ack), .o_m0_err(o_m0_err),
        .o_m1_dat(o_m1_dat), .o_m1_ack(o_m1_ack), .o_m1_err(o_m1_err),
        .o_s_adr(o_s_adr), .o_s_we(o_s_we), .o_s_dat(o_s_dat), .o_s_stb(o_s_stb),
        .i_s_dat(i_s_dat), .i_s_ack(i_s_ack), .i_s_err(i_s_err),
        .o_owner(o_owner), .o_busy(o_busy)
    );

    int checks = 0;
    int fails  = 0;

    // Reference model: who owns the slave, who owned it last, how long it has waited
    bit m_busy, m_owner, m_last;
    int m_cnt;
    // Completion seen by each master in the last checked cycle
    bit g_done0, g_done1;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = 1'b0;
        m_last  = 1'b1;
        m_cnt   = 0;
    endtask

    // One clock: check all outputs mid-cycle against the model, then advance it
    task automatic tick(input string tag);
        logic [AW-1:0] e_adr;
        logic          e_we, e_stb;
        logic [DW-1:0] e_sdat, e_d0, e_d1;
        logic          e_a0, e_a1, e_e0, e_e1;
        bit            n_busy, n_owner, n_last, req, resp, wd;
        int            n_cnt;
        @(negedge i_clk);
        e_adr = '0; e_we = 1'b0; e_sdat = '0; e_stb = 1'b0;
        e_d0 = '0; e_d1 = '0; e_a0 = 1'b0; e_a1 = 1'b0; e_e0 = 1'b0; e_e1 = 1'b0;
        n_busy = m_busy; n_owner = m_owner; n_last = m_last; n_cnt = m_cnt;
        if (m_busy) begin
            req  = m_owner ? i_m1_stb : i_m0_stb;
            resp = i_s_ack || i_s_err;
            wd   = 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
            wd   = !resp && (m_cnt + 1 == TIMEOUT);
`endif
            e_adr  = m_owner ? i_m1_adr : i_m0_adr;
            e_we   = m_owner ? i_m1_we  : i_m0_we;
            e_sdat = m_owner ? i_m1_dat : i_m0_dat;
            e_stb  = req && !wd;
            if (req) begin
                if (m_owner) begin
                    e_d1 = i_s_dat; e_a1 = i_s_ack && !i_s_err; e_e1 = i_s_err || wd;
                end else begin
                    e_d0 = i_s_dat; e_a0 = i_s_ack && !i_s_err; e_e0 = i_s_err || wd;
                end
            end
            if (!req || resp || wd) begin
                n_busy = 1'b0;
                n_last = m_owner;
            end else begin
                n_cnt = m_cnt + 1;
            end
        end else if (i_m0_stb || i_m1_stb) begin
            n_busy  = 1'b1;
            n_owner = (i_m0_stb && i_m1_stb) ? !m_last : i_m1_stb;
            n_cnt   = 0;
        end
        chk({tag, ":slave"}, 128'({o_s_adr, o_s_we, o_s_dat, o_s_stb}),
                              128'({e_adr, e_we, e_sdat, e_stb}));
        chk({tag, ":m0"}, 128'({o_m0_dat, o_m0_ack, o_m0_err}), 128'({e_d0, e_a0, e_e0}));
        chk({tag, ":m1"}, 128'({o_m1_dat, o_m1_ack, o_m1_err}), 128'({e_d1, e_a1, e_e1}));
        chk({tag, ":status"}, 128'({o_owner, o_busy}), 128'({m_owner, m_busy}));
        g_done0 = e_a0 || e_e0;
        g_done1 = e_a1 || e_e1;
        if (g_done0 || g_done1)
            $display("txn m%0d adr=%h we=%0d %s dat=%h", m_owner, e_adr, e_we,
                     (e_e0 || e_e1) ? "err" : "ack", i_s_dat);
        @(posedge i_clk);
        m_busy = n_busy; m_owner = n_owner; m_last = n_last; m_cnt = n_cnt;
        #1;
    endtask

    logic [3:0] grants;

    initial begin
        i_rst_n = 1'b0;
        i_m0_adr = '0; i_m0_we = 1'b0; i_m0_dat = '0; i_m0_stb = 1'b1;
        i_m1_adr = '0; i_m1_we = 1'b0; i_m1_dat = '0; i_m1_stb = 1'b1;
        i_s_dat = '0; i_s_ack = 1'b0; i_s_err = 1'b0;
        model_reset();

        // Reset held with both masters requesting: everything quiet
        #1;
        chk("rst_m", 128'({o_m0_dat, o_m0_ack, o_m0_err, o_m1_dat, o_m1_ack, o_m1_err}), 128'(0));
        chk("rst_s", 128'({o_s_adr, o_s_we, o_s_dat, o_s_stb, o_owner, o_busy}), 128'(0));
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_s_hold", 128'({o_s_adr, o_s_we, o_s_dat, o_s_stb, o_owner, o_busy}), 128'(0));
        i_rst_n = 1'b1;
        tick("rst_rel");
        chk("first_grant", 128'({o_owner, o_busy}), 128'(2'b01));
        i_m0_stb = 1'b0; i_m1_stb = 1'b0;
        tick("abort"); tick("idle");

        // m0 write with one wait state
        i_m0_adr = 32'h10; i_m0_dat = 32'hA5; i_m0_we = 1'b1; i_m0_stb = 1'b1;
        tick("wr_req");
        chk("wr_slave", 128'({o_s_adr, o_s_we, o_s_dat, o_s_stb}),
                        128'({32'h10, 1'b1, 32'hA5, 1'b1}));
        chk("wr_wait_ack", 128'(o_m0_ack), 128'(0));
        tick("wr_wait");
        i_s_ack = 1'b1;
        #1;
        chk("wr_ack", 128'(o_m0_ack), 128'(1));
        chk("wr_m1_quiet", 128'({o_m1_dat, o_m1_ack, o_m1_err}), 128'(0));
        tick("wr_ack");
        i_s_ack = 1'b0; i_m0_stb = 1'b0; i_m0_we = 1'b0;
        #1;
        chk("wr_ack_pulse", 128'({o_m0_ack, o_busy}), 128'(0));
        tick("wr_idle");

        // Fresh reset, then contention with zero-wait slave
        i_rst_n = 1'b0;
        #1;
        model_reset();
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        i_m0_stb = 1'b1; i_m1_stb = 1'b1; i_m1_we = 1'b0; i_m1_adr = 32'h4;
        i_s_dat = 32'hDEADBEEF; i_s_ack = 1'b1;
        tick("rr_req");
        grants = '0;
        for (int i = 0; i < 8; i++) begin
            chk("rr_gap", 128'(o_busy), 128'((i % 2) == 0));
            if (o_busy) grants = {grants[2:0], o_owner};
            if (o_busy && o_owner) chk("rr_m1_dat", 128'({o_m1_dat, o_m1_ack}), 128'({32'hDEADBEEF, 1'b1}));
            tick("rr");
        end
        chk("rr_order", 128'(grants), 128'(4'b0101));
        i_m0_stb = 1'b0; i_m1_stb = 1'b0; i_s_ack = 1'b0;
        tick("rr_drain"); tick("rr_idle");

        // Simultaneous ack and err for m1: err wins
        i_m1_stb = 1'b1;
        tick("ae_req");
        i_s_ack = 1'b1; i_s_err = 1'b1;
        #1;
        chk("ae_m1", 128'({o_m1_err, o_m1_ack}), 128'(2'b10));
        tick("ae");
        chk("ae_idle", 128'(o_busy), 128'(0));
        i_m1_stb = 1'b0; i_s_ack = 1'b0; i_s_err = 1'b0;
        tick("ae_rest");

        // Silent slave with m1 waiting behind m0
        i_m0_stb = 1'b1; i_m1_stb = 1'b1;
        tick("wd_req");
        chk("wd_grant", 128'({o_owner, o_busy}), 128'(2'b01));
`ifdef WB_ARB_TIMEOUT_EN
        for (int k = 1; k <= TIMEOUT; k++) begin
            chk("wd_err", 128'({o_m0_err, o_s_stb}), 128'({k == TIMEOUT, k != TIMEOUT}));
            tick("wd");
        end
        i_m0_stb = 1'b0;
        chk("wd_idle", 128'(o_busy), 128'(0));
`else
        for (int k = 1; k <= 20; k++) begin
            chk("nowd_wait", 128'({o_m0_err, o_busy}), 128'(2'b01));
            tick("nowd");
        end
        i_s_ack = 1'b1;
        tick("nowd_ack");
        i_s_ack = 1'b0; i_m0_stb = 1'b0;
        chk("nowd_idle", 128'(o_busy), 128'(0));
`endif
        tick("wd_gap");
        chk("wd_m1_grant", 128'({o_owner, o_busy}), 128'(2'b11));

        // Asynchronous reset during m1's transaction
        i_s_ack = 1'b1; i_s_dat = 32'h1234_5678;
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("arst_quiet", 128'({o_s_stb, o_m1_ack, o_m1_err, o_m1_dat, o_busy}), 128'(0));
        model_reset();
        @(posedge i_clk); #1;
        chk("arst_hold", 128'({o_s_stb, o_m1_ack, o_m1_err, o_busy}), 128'(0));
        i_rst_n = 1'b1; i_s_ack = 1'b0; i_m0_stb = 1'b1;
        tick("arst_rel");
        chk("arst_m0_first", 128'({o_owner, o_busy}), 128'(2'b01));
        i_m0_stb = 1'b0; i_m1_stb = 1'b0;
        tick("arst_drain"); tick("arst_idle");

        // Randomized traffic: masters hold stb until served (rare aborts)
        g_done0 = 1'b0; g_done1 = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (i_m0_stb && (g_done0 ? ($urandom_range(1) == 0) : ($urandom_range(31) == 0)))
                i_m0_stb = 1'b0;
            else if (!i_m0_stb && $urandom_range(2) == 0) begin
                i_m0_stb = 1'b1; i_m0_adr = $urandom; i_m0_we = 1'($urandom); i_m0_dat = $urandom;
            end
            if (i_m1_stb && (g_done1 ? ($urandom_range(1) == 0) : ($urandom_range(31) == 0)))
                i_m1_stb = 1'b0;
            else if (!i_m1_stb && $urandom_range(2) == 0) begin
                i_m1_stb = 1'b1; i_m1_adr = $urandom; i_m1_we = 1'($urandom); i_m1_dat = $urandom;
            end
            i_s_ack = ($urandom_range(2) == 0);
            i_s_err = ($urandom_range(7) == 0);
            i_s_dat = $urandom;
            tick("rand");
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
